// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle controller.
// Contents:
//   state_t  - FSM state encoding (also driven out on the debug state port)
//   iclass_t - instruction class latched in DECODE
//   TYPE_*   - instruction-type field codes from the decoder
//   OP_*     - opcodes that select a non-ALU class
//   PC_SEL_* - PC source select codes
//   classify - maps {type, op} to an instruction class
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam int OPC_W = 5;
    localparam int TYP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_LOAD   = 3'd1,
        CL_STORE  = 3'd2,
        CL_BRANCH = 3'd3,
        CL_JUMP   = 3'd4
    } iclass_t;

    localparam logic [TYP_W-1:0] TYPE_R = 2'd0;
    localparam logic [TYP_W-1:0] TYPE_I = 2'd1;
    localparam logic [TYP_W-1:0] TYPE_J = 2'd2;
    localparam logic [TYP_W-1:0] TYPE_S = 2'd3;

    localparam logic [OPC_W-1:0] OP_LW  = 5'd4;
    localparam logic [OPC_W-1:0] OP_SW  = 5'd5;
    localparam logic [OPC_W-1:0] OP_BEQ = 5'd8;
    localparam logic [OPC_W-1:0] OP_J   = 5'd12;

    localparam logic [1:0] PC_SEL_INC    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    // A J-type field always means a jump; otherwise the opcode picks the
    // memory / control-flow classes and everything else is an ALU op.
    function automatic iclass_t classify(input logic [OPC_W-1:0] op,
                                         input logic [TYP_W-1:0] typ);
        iclass_t cls;
        cls = CL_ALU;
        case (typ)
            TYPE_J: cls = CL_JUMP;
            TYPE_R, TYPE_I, TYPE_S: begin
                if (op == OP_LW)       cls = CL_LOAD;
                else if (op == OP_SW)  cls = CL_STORE;
                else if (op == OP_BEQ) cls = CL_BRANCH;
                else if (op == OP_J)   cls = CL_JUMP;
                else                   cls = CL_ALU;
            end
            default: cls = CL_ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive memory wait cycles and flags the last allowed one.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_clear      - restart the count (has priority over i_count_en)
//   i_count_en   - current cycle is a wait cycle (request pending, no ack)
//   o_expired    - this wait cycle is number 2**TO_W-1 in a row
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TO_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    // r_cnt holds the number of earlier wait cycles, so the cycle that sees
    // LAST_WAIT is itself the (2**TO_W-1)-th wait.
    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'((2 ** TO_W) - 2);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expired = i_count_en && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle main controller: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB, drives the per-state datapath strobes, handshakes with a
// shared memory port (with a bounded wait), tracks halt and retired count.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   i_run_en            - allows leaving IDLE
//   i_op, i_type, i_stop- decoder fields, sampled in DECODE
//   i_zero              - ALU zero flag, used in EXEC for branches
//   i_mem_ack           - memory completion strobe
//   o_mem_req, o_mem_we - memory request and write qualifier
//   o_ir_we             - instruction-register load
//   o_pc_we, o_pc_sel   - PC update and source (+1 / branch / jump)
//   o_alu_en            - ALU operation strobe
//   o_reg_we, o_wb_sel  - register write and source (ALU / memory)
//   o_state             - current state (debug)
//   o_halted, o_err     - halted, sticky memory timeout
//   o_retired           - retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter int TYPE_W = 2,
    parameter int TO_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run_en,
    input  logic [OP_W-1:0]   i_op,
    input  logic [TYPE_W-1:0] i_type,
    input  logic              i_stop,
    input  logic              i_zero,
    input  logic              i_mem_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic              o_ir_we,
    output logic              o_pc_we,
    output logic [1:0]        o_pc_sel,
    output logic              o_alu_en,
    output logic              o_reg_we,
    output logic              o_wb_sel,
    output logic [2:0]        o_state,
    output logic              o_halted,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_retired
);

    state_t             r_state;
    state_t             w_state_next;
    iclass_t            r_class;
    logic               r_stop;
    logic               r_err;
    logic [CNT_W-1:0]   r_retired;

    logic               w_retire;
    logic               w_timeout;
    logic               w_in_wait;
    logic               w_expired;

    // Wait timer: counts only while a request is outstanding and unanswered.
    assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);

    mem_wait_timer #(
        .TO_W (TO_W)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (!w_in_wait || i_mem_ack),
        .i_count_en (w_in_wait && !i_mem_ack),
        .o_expired  (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction context, sticky error and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_class   <= CL_ALU;
            r_stop    <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_class <= classify(OPC_W'(i_op), TYP_W'(i_type));
                r_stop  <= i_stop;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Next-state logic. An ack always takes priority over the timer, so an
    // ack on the last permitted wait cycle completes normally.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run_en) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_mem_ack) begin
                    w_state_next = ST_DECODE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_HALT;
                end
            end
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC: begin
                case (r_class)
                    CL_LOAD, CL_STORE:   w_state_next = ST_MEM;
                    CL_BRANCH, CL_JUMP:  w_retire     = 1'b1;
                    default:             w_state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    if (r_class == CL_STORE) w_retire     = 1'b1;
                    else                     w_state_next = ST_WB;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_HALT;
                end
            end
            ST_WB:   w_retire     = 1'b1;
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_IDLE;
        endcase
        // Retirement goes straight to the next fetch (or halt); IDLE is
        // only revisited through reset.
        if (w_retire) begin
            w_state_next = r_stop ? ST_HALT : ST_FETCH;
        end
    end

    // Output decode from state and latched class. Strobes that depend on
    // ack/zero only qualify the cycle in which they are asserted.
    always_comb begin
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_ir_we   = 1'b0;
        o_pc_we   = 1'b0;
        o_pc_sel  = PC_SEL_INC;
        o_alu_en  = 1'b0;
        o_reg_we  = 1'b0;
        o_wb_sel  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_we   = i_mem_ack;
            end
            ST_EXEC: begin
                o_alu_en = 1'b1;
                if (r_class == CL_BRANCH) begin
                    o_pc_we  = 1'b1;
                    o_pc_sel = i_zero ? PC_SEL_BRANCH : PC_SEL_INC;
                end else if (r_class == CL_JUMP) begin
                    o_pc_we  = 1'b1;
                    o_pc_sel = PC_SEL_JUMP;
                end
            end
            ST_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = (r_class == CL_STORE);
                o_pc_we   = (r_class == CL_STORE) && i_mem_ack;
            end
            ST_WB: begin
                o_reg_we = 1'b1;
                o_wb_sel = (r_class == CL_LOAD);
                o_pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state   = r_state;
    assign o_halted  = (r_state == ST_HALT);
    assign o_err     = r_err;
    assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Drives programs of instructions, acting as decoder and memory, and checks
// every cycle's outputs against a phase-level model of each instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BR    = 3;
    localparam int K_JMP   = 4;
    localparam int LAST_W  = 14;   // index of the 15th consecutive wait cycle

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic [4:0]  op = '0;
    logic [1:0]  typ = '0;
    logic        stop = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;

    logic        o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_alu_en, o_reg_we, o_wb_sel;
    logic        o_halted, o_err;
    logic [1:0]  o_pc_sel;
    logic [2:0]  o_state;
    logic [15:0] o_retired;

    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] exp_retired = '0;
    logic        exp_err = 1'b0;
    int          res;

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run_en  (run_en),
        .i_op      (op),
        .i_type    (typ),
        .i_stop    (stop),
        .i_zero    (zero),
        .i_mem_ack (mem_ack),
        .o_mem_req (o_mem_req),
        .o_mem_we  (o_mem_we),
        .o_ir_we   (o_ir_we),
        .o_pc_we   (o_pc_we),
        .o_pc_sel  (o_pc_sel),
        .o_alu_en  (o_alu_en),
        .o_reg_we  (o_reg_we),
        .o_wb_sel  (o_wb_sel),
        .o_state   (o_state),
        .o_halted  (o_halted),
        .o_err     (o_err),
        .o_retired (o_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs();
        return {2'b00, o_retired, o_state, o_mem_req, o_mem_we, o_ir_we, o_pc_we,
                o_pc_sel, o_alu_en, o_reg_we, o_wb_sel, o_halted, o_err};
    endfunction

    // Expected output vector for one cycle
    function automatic logic [31:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic ir, input logic pcw, input logic [1:0] pcs,
                                       input logic alu, input logic rw, input logic wbs);
        return {2'b00, exp_retired, st, req, we, ir, pcw, pcs, alu, rw, wbs,
                (st == 3'd6), exp_err};
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag, input logic [31:0] want);
        #1;
        chk(tag, obs(), want);
        @(negedge clk);
    endtask

    task automatic junk();
        mem_ack = 1'($urandom_range(0, 1));
        zero    = 1'($urandom_range(0, 1));
    endtask

    task automatic start_program();
        rst_n = 1'b0;
        run_en = 1'b0;
        mem_ack = 1'b0;
        exp_retired = '0;
        exp_err = 1'b0;
        #1;
        chk("reset", obs(), ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        junk();
        step("idle", ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        run_en = 1'b1;
        junk();
        step("idle_go", ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
    endtask

    task automatic halt_check(input int n);
        for (int i = 0; i < n; i++) begin
            run_en = 1'b1;
            junk();
            step("halt", ev(3'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        end
    endtask

    task automatic encode(input int k, output logic [4:0] o, output logic [1:0] t);
        if (k == K_LOAD) begin
            o = OP_LW;  t = TYPE_I;
        end else if (k == K_STORE) begin
            o = OP_SW;  t = TYPE_S;
        end else if (k == K_BR) begin
            o = OP_BEQ; t = TYPE_I;
        end else if (k == K_JMP) begin
            o = OP_J;   t = TYPE_J;
        end else begin
            do o = 5'($urandom_range(0, 31));
            while (o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J);
            t = ($urandom_range(0, 1) == 1) ? TYPE_I : TYPE_R;
        end
    endtask

    // res: 0 = retired, continue; 1 = retired into HALT; 2 = timeout; 3 = aborted by reset
    task automatic run_instr(input int k, input logic stp, input logic z, input int fw,
                             input int mw, input int abort_at, output int r);
        logic [4:0] o;
        logic [1:0] t;
        logic       is_st;
        encode(k, o, t);
        is_st = (k == K_STORE);
        r = 0;
        $display("instr kind=%0d op=%0d type=%0d stop=%0b zero=%0b fetch_wait=%0d mem_wait=%0d abort=%0d retired_before=%0d",
                 k, o, t, stp, z, fw, mw, abort_at, exp_retired);
        // FETCH: decoder fields are garbage until DECODE
        for (int i = 0; i <= LAST_W; i++) begin
            op   = 5'($urandom_range(0, 31));
            typ  = 2'($urandom_range(0, 3));
            stop = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            if (i == fw) begin
                mem_ack = 1'b1;
                step("fetch_ack", ev(3'd1, 1, 0, 1, 0, 2'd0, 0, 0, 0));
                break;
            end
            mem_ack = 1'b0;
            step("fetch_wait", ev(3'd1, 1, 0, 0, 0, 2'd0, 0, 0, 0));
            if (i == LAST_W) begin
                exp_err = 1'b1;
                r = 2;
                return;
            end
        end
        // DECODE
        op = o; typ = t; stop = stp;
        junk();
        step("decode", ev(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        // EXEC
        mem_ack = 1'($urandom_range(0, 1));
        zero = z;
        if (k == K_BR || k == K_JMP) begin
            step("exec_pc", ev(3'd3, 0, 0, 0, 1, (k == K_JMP) ? 2'd2 : {1'b0, z}, 1, 0, 0));
            exp_retired++;
            r = stp ? 1 : 0;
            return;
        end
        step("exec", ev(3'd3, 0, 0, 0, 0, 2'd0, 1, 0, 0));
        // MEM
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= LAST_W; i++) begin
                zero = 1'($urandom_range(0, 1));
                if (i == abort_at) begin
                    mem_ack = 1'($urandom_range(0, 1));
                    rst_n = 1'b0;
                    exp_retired = '0;
                    exp_err = 1'b0;
                    #1;
                    chk("abort", obs(), ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
                    r = 3;
                    return;
                end
                if (i == mw) begin
                    mem_ack = 1'b1;
                    if (is_st) begin
                        step("mem_ack_st", ev(3'd4, 1, 1, 0, 1, 2'd0, 0, 0, 0));
                        exp_retired++;
                        r = stp ? 1 : 0;
                        return;
                    end
                    step("mem_ack_ld", ev(3'd4, 1, 0, 0, 0, 2'd0, 0, 0, 0));
                    break;
                end
                mem_ack = 1'b0;
                step("mem_wait", ev(3'd4, 1, is_st, 0, 0, 2'd0, 0, 0, 0));
                if (i == LAST_W) begin
                    exp_err = 1'b1;
                    r = 2;
                    return;
                end
            end
        end
        // WB
        junk();
        step("wb", ev(3'd5, 0, 0, 0, 1, 2'd0, 0, 1, (k == K_LOAD)));
        exp_retired++;
        r = stp ? 1 : 0;
    endtask

    function automatic int rand_wait();
        int s;
        s = $urandom_range(0, 19);
        if (s < 15) return s % 4;
        if (s < 17) return LAST_W;
        return LAST_W + 1 + $urandom_range(0, 3);
    endfunction

    initial begin
        @(negedge clk);

        // ALU x2 back to back, then a LOAD with a 3-cycle data wait and stop
        start_program();
        run_instr(K_ALU, 1'b0, 1'b0, 0, 0, -1, res);
        run_instr(K_ALU, 1'b0, 1'b1, 1, 0, -1, res);
        run_instr(K_LOAD, 1'b1, 1'b0, 0, 3, -1, res);
        halt_check(3);

        // STORE, BEQ taken, BEQ not taken, JUMP with stop
        start_program();
        run_instr(K_STORE, 1'b0, 1'b0, 0, 1, -1, res);
        run_instr(K_BR, 1'b0, 1'b1, 0, 0, -1, res);
        run_instr(K_BR, 1'b0, 1'b0, 2, 0, -1, res);
        run_instr(K_JMP, 1'b1, 1'b0, 0, 0, -1, res);
        halt_check(20);

        // Fetch timeout, then the same with ack on the last allowed wait
        start_program();
        run_instr(K_ALU, 1'b0, 1'b0, 30, 0, -1, res);
        halt_check(4);
        start_program();
        run_instr(K_ALU, 1'b0, 1'b0, LAST_W, 0, -1, res);
        run_instr(K_LOAD, 1'b0, 1'b0, 0, LAST_W, -1, res);
        run_instr(K_STORE, 1'b1, 1'b0, 0, 20, -1, res);
        halt_check(4);

        // Reset in the middle of a STORE's memory phase
        start_program();
        run_instr(K_ALU, 1'b0, 1'b0, 0, 0, -1, res);
        run_instr(K_STORE, 1'b0, 1'b0, 0, 5, 2, res);
        mem_ack = 1'b1;
        step("abort_hold", ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));

        // Random programs
        for (int p = 0; p < 12; p++) begin
            int n;
            start_program();
            n = $urandom_range(3, 9);
            res = 0;
            for (int j = 0; j < n && res == 0; j++) begin
                int  k;
                int  ab;
                logic s;
                k  = $urandom_range(0, 4);
                s  = ($urandom_range(0, 5) == 0) || (j == n - 1 && $urandom_range(0, 1) == 1);
                ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
                run_instr(k, s, 1'($urandom_range(0, 1)), rand_wait(), rand_wait(), ab, res);
            end
            if (res == 1 || res == 2) begin
                halt_check(5);
            end else if (res == 3) begin
                step("abort_hold", ev(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
